// File: rtl/design_bist_pkg.sv
// Shared types and helpers for the BIST controller: FSM states, LFSR/MISR polynomial and step function.
package design_bist_pkg;

  localparam int          SIG_W     = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // One right-shifting Galois step; shared by the pattern LFSR and the MISR feedback.
  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : {SIG_W{1'b0}});
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Signature register compacting block responses; DESIGN_BIST_PIPE_EN adds a response register in front.
// With the pipe, each response is absorbed one cycle after it is captured.
module bist_misr
  import design_bist_pkg::*;
#(
  parameter int PO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PO_W-1:0]  resp_i,
  output logic [SIG_W-1:0] misr_o
);

  logic [SIG_W-1:0] misr_q, misr_d;
  logic             absorb;
  logic [PO_W-1:0]  absorb_dat;

`ifdef DESIGN_BIST_PIPE_EN
  logic [PO_W-1:0] resp_q;
  logic            vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      resp_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= en_i;
      if (en_i) resp_q <= resp_i;
    end
  end

  assign absorb     = vld_q;
  assign absorb_dat = resp_q;
`else
  assign absorb     = en_i;
  assign absorb_dat = resp_i;
`endif

  always_comb begin
    misr_d = misr_q;
    if (clr_i)       misr_d = '0;
    else if (absorb) misr_d = lfsr_step(misr_q) ^ SIG_W'(absorb_dat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misr_q <= '0;
    else        misr_q <= misr_d;
  end

  assign misr_o = misr_q;

endmodule

// File: rtl/design_bist_ctrl.sv
// LFSR/MISR BIST controller for a combinational block; start-to-done is N+2 cycles (N+3 with DESIGN_BIST_PIPE_EN).
// start is ignored while busy; sig/pass are held from the done cycle until the next run's SEED.
module design_bist_ctrl
  import design_bist_pkg::*;
#(
  parameter int          PI_W        = 14,
  parameter int          PO_W        = 8,
  parameter int          PATTERN_CNT = 1024,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [PI_W-1:0]  pi,
  input  logic [PO_W-1:0]  po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam int               CNT_W    = $clog2(PATTERN_CNT + 1);
  localparam logic [15:0]      SEED_VAL = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PATTERN_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             misr_clr, misr_en;
  logic [SIG_W-1:0] misr;
  logic             match;

  assign match = (misr == golden_sig);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = SEED;
      SEED: begin
        lfsr_d   = SEED_VAL;
        cnt_d    = '0;
        sig_d    = '0;
        pass_d   = 1'b0;
        misr_clr = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        misr_en = 1'b1;
        lfsr_d  = lfsr_step(lfsr_q);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef DESIGN_BIST_PIPE_EN
          state_d = DRAIN;
`else
          state_d = DONE;
`endif
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        sig_d   = misr;
        pass_d  = match;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  bist_misr #(.PO_W(PO_W)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .resp_i (po),
    .misr_o (misr)
  );

  // The final signature is already in the MISR during DONE, so expose it that same cycle.
  assign pi   = (state_q == RUN) ? lfsr_q[PI_W-1:0] : '0;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sig  = done ? misr  : sig_q;
  assign pass = done ? match : pass_q;

endmodule

// File: tb/tb_design_bist_ctrl.sv
// Directed bench: three controller instances (N=1024, 1, 2) driven from a vector table plus corner-case sequences.
module tb_design_bist_ctrl;

`ifdef DESIGN_BIST_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NBIG = 1024;

  logic        clk, rst_n;
  logic        start_r  [3];
  logic [15:0] golden_r [3];
  logic [7:0]  po_r     [3];
  logic [13:0] pi_w     [3];
  logic        busy_w   [3];
  logic        done_w   [3];
  logic        pass_w   [3];
  logic [15:0] sig_w    [3];

  int checks = 0;
  int errors = 0;

  design_bist_ctrl #(.PATTERN_CNT(NBIG)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .golden_sig(golden_r[0]), .pi(pi_w[0]),
    .po(po_r[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .sig(sig_w[0]));
  design_bist_ctrl #(.PATTERN_CNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .golden_sig(golden_r[1]), .pi(pi_w[1]),
    .po(po_r[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .sig(sig_w[1]));
  design_bist_ctrl #(.PATTERN_CNT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .golden_sig(golden_r[2]), .pi(pi_w[2]),
    .po(po_r[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .sig(sig_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          d;
    logic [7:0]  po;
    logic [15:0] golden;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Constant-response signature: m <- galois_step(m) ^ p, repeated n times from 0.
  function automatic logic [15:0] model_sig(input int n, input logic [7:0] p);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < n; i++)
      m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000) ^ {8'h00, p};
    return m;
  endfunction

  // Pulses start on instance d and returns after the done cycle is observed (#1 after its edge).
  task automatic run(input int d, input logic [7:0] p, input logic [15:0] g, input int budget,
                     output int lat);
    @(negedge clk);
    po_r[d] = p; golden_r[d] = g; start_r[d] = 1'b1;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    lat = 1;
    while (!done_w[d] && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t        vecs [9];
  int          lat, gap, npulse;
  logic [15:0] exp;

  initial begin
    vecs[0] = '{1, 8'h01, 16'h0001, 16'h0001, 1'b1};
    vecs[1] = '{1, 8'hA5, 16'h00A5, 16'h00A5, 1'b1};
    vecs[2] = '{1, 8'hA5, 16'h00A4, 16'h00A5, 1'b0};
    vecs[3] = '{2, 8'h01, 16'hB400, 16'hB401, 1'b0};
    vecs[4] = '{2, 8'h01, 16'hB401, 16'hB401, 1'b1};
    vecs[5] = '{2, 8'hFF, 16'hB480, 16'hB480, 1'b1};
    vecs[6] = '{2, 8'h80, 16'h00C0, 16'h00C0, 1'b1};
    vecs[7] = '{2, 8'h00, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{2, 8'h02, 16'h0003, 16'h0003, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; po_r[i] = 8'h00; golden_r[i] = 16'h0;
    end
    #22;
    chk("reset_pi",   32'(pi_w[0]),   32'h0);
    chk("reset_busy", 32'(busy_w[0]), 32'h0);
    chk("reset_done", 32'(done_w[0]), 32'h0);
    chk("reset_pass", 32'(pass_w[0]), 32'h0);
    chk("reset_sig",  32'(sig_w[0]),  32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Default run with po=0: first two RUN vectors, latency, zero signature.
    @(negedge clk);
    po_r[0] = 8'h00; golden_r[0] = 16'h0000; start_r[0] = 1'b1;
    @(posedge clk); #1; start_r[0] = 1'b0;
    chk("seed_busy", 32'(busy_w[0]), 32'h1);
    chk("seed_pi",   32'(pi_w[0]),   32'h0);
    @(posedge clk); #1;
    chk("run_pi0", 32'(pi_w[0]), 32'h2CE1);
    @(posedge clk); #1;
    chk("run_pi1", 32'(pi_w[0]), 32'h2270);
    lat = 3;
    while (!done_w[0] && lat < NBIG + 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("s1_latency", 32'(lat), 32'(NBIG + 2 + EXTRA));
    chk("s1_sig",  32'(sig_w[0]),  32'h0);
    chk("s1_pass", 32'(pass_w[0]), 32'h1);
    chk("s1_done_busy", 32'(busy_w[0]), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("s1_idle_done", 32'(done_w[0]), 32'h0);
    chk("s1_idle_busy", 32'(busy_w[0]), 32'h0);
    chk("s1_pass_held", 32'(pass_w[0]), 32'h1);

    // Table of short runs on the N=1 and N=2 instances.
    foreach (vecs[i]) begin
      run(vecs[i].d, vecs[i].po, vecs[i].golden, 20, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].d + 2 + EXTRA));
      chk($sformatf("vec%0d_sig", i),  32'(sig_w[vecs[i].d]),  32'(vecs[i].exp_sig));
      chk($sformatf("vec%0d_pass", i), 32'(pass_w[vecs[i].d]), 32'(vecs[i].exp_pass));
      @(posedge clk); @(posedge clk); #1;
      chk($sformatf("vec%0d_sig_held", i), 32'(sig_w[vecs[i].d]), 32'(vecs[i].exp_sig));
    end

    // start re-pulsed mid-RUN must be ignored.
    exp = model_sig(NBIG, 8'h33);
    @(negedge clk);
    po_r[0] = 8'h33; golden_r[0] = exp; start_r[0] = 1'b1;
    @(posedge clk); #1; start_r[0] = 1'b0;
    lat = 1;
    while (!done_w[0] && lat < NBIG + 10) begin
      @(posedge clk); #1; lat++;
      if (lat == 40) start_r[0] = 1'b1;
      if (lat == 41) start_r[0] = 1'b0;
    end
    chk("restart_latency", 32'(lat), 32'(NBIG + 2 + EXTRA));
    chk("restart_sig",  32'(sig_w[0]),  32'(exp));
    chk("restart_pass", 32'(pass_w[0]), 32'h1);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_w[0]) npulse++;
    end
    chk("restart_extra_done", 32'(npulse), 32'h0);

    // Reset mid-RUN clears everything; a fresh run reproduces the full signature.
    exp = model_sig(NBIG, 8'h77);
    run(0, 8'h77, exp, 100, lat);
    chk("midrst_still_busy", 32'(busy_w[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pi",   32'(pi_w[0]),   32'h0);
    chk("midrst_busy", 32'(busy_w[0]), 32'h0);
    chk("midrst_pass", 32'(pass_w[0]), 32'h0);
    chk("midrst_sig",  32'(sig_w[0]),  32'h0);
    @(negedge clk); rst_n = 1'b1;
    run(0, 8'h77, exp, NBIG + 10, lat);
    chk("postrst_latency", 32'(lat), 32'(NBIG + 2 + EXTRA));
    chk("postrst_sig",  32'(sig_w[0]),  32'(exp));
    chk("postrst_pass", 32'(pass_w[0]), 32'h1);

    // start held high re-triggers: second done follows N+3 cycles after the first.
    @(negedge clk);
    po_r[1] = 8'h5C; golden_r[1] = 16'h005C; start_r[1] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done_w[1] && lat < 20);
    chk("hold_first_latency", 32'(lat), 32'(3 + EXTRA));
    gap = 0;
    do begin
      @(posedge clk); #1; gap++;
    end while (!done_w[1] && gap < 20);
    chk("hold_gap", 32'(gap), 32'(4 + EXTRA));
    chk("hold_sig", 32'(sig_w[1]), 32'h005C);
    @(negedge clk); start_r[1] = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    chk("final_idle", 32'(busy_w[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
